reg_wb_writer: RTL and testbench



---
 rtl/reg_wb_pkg.sv | 20 ++
 rtl/reg_wb_fifo.sv | 77 +++++++
 rtl/reg_wb_writer.sv | 147 ++++++++++++++
 tb/tb_reg_wb_writer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_wb_pkg.sv
// Shared types and constants for the register-file write-back front end.
package reg_wb_pkg;

    localparam int REG_AW = 4;
    localparam int REG_DW = 32;

    localparam logic [REG_AW-1:0] INIT_LAST = REG_AW'((1 << REG_AW) - 1);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] addr;
        logic [REG_DW-1:0] data;
    } wb_entry_t;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } wb_state_t;

endpackage

// File: rtl/reg_wb_fifo.sv
// Load write-back FIFO whose entries can be squashed in place by address.
// Squashed entries keep their slot and are popped later without issuing a write.
module reg_wb_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 4,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [AW-1:0]            push_addr,
    input  logic [DW-1:0]            push_data,
    input  logic                     pop,
    input  logic                     squash,
    input  logic [AW-1:0]            squash_addr,
    input  logic [AW-1:0]            query_addr,
    output logic                     head_valid,
    output logic [AW-1:0]            head_addr,
    output logic [DW-1:0]            head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     query_hit
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0] valid;
    logic [AW-1:0]    addr_mem [DEPTH];
    logic [DW-1:0]    data_mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;

    // Push is applied last so a same-cycle push into the slot being popped survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (squash && valid[i] && addr_mem[i] == squash_addr) begin
                    valid[i] <= 1'b0;
                end
            end
            if (pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + PW'(1);
            end
            if (push) begin
                valid[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= push_data;
        end
    end

    always_comb begin
        query_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && addr_mem[i] == query_addr) begin
                query_hit = 1'b1;
            end
        end
    end

    assign head_valid = valid[rd_ptr];
    assign head_addr  = addr_mem[rd_ptr];
    assign head_data  = data_mem[rd_ptr];

endmodule

// File: rtl/reg_wb_writer.sv
// Merges ALU and load write-backs onto the register file's single write port.
// Define REG_WB_INIT_EN to zero-fill the register file after reset.
//
// state | meaning
// INIT  | sweeping zeros into every register, requests refused
// RUN   | normal arbitration: ALU first, then FIFO head
module reg_wb_writer
    import reg_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = REG_AW,
    parameter int DW    = REG_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          alu_valid,
    output logic          alu_ready,
    input  logic [AW-1:0] alu_addr,
    input  logic [DW-1:0] alu_data,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_pending,
    output logic          init_done,
    output logic          wea,
    output logic [AW-1:0] addra,
    output logic [DW-1:0] dina
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0] SWEEP_LAST = '1;

`ifdef REG_WB_INIT_EN
    localparam wb_state_t RESET_STATE = ST_INIT;
`else
    localparam wb_state_t RESET_STATE = ST_RUN;
`endif

    wb_state_t     state;
    wb_state_t     state_next;
    logic          run_q;
    logic [AW-1:0] sweep_addr;
    logic [AW-1:0] sweep_next;
    logic          wea_next;
    logic [AW-1:0] addr_next;
    logic [DW-1:0] data_next;
    logic          alu_fire;
    logic          fifo_pop;
    logic          fifo_push;
    logic          fifo_hit;
    logic          head_valid;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data;
    logic [CW-1:0] fifo_count;

    // run_q lags state by a cycle so requests open only after the last sweep write is visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RESET_STATE;
            sweep_addr <= '0;
            run_q      <= 1'b0;
            wea        <= 1'b0;
            addra      <= '0;
            dina       <= '0;
        end else begin
            state      <= state_next;
            sweep_addr <= sweep_next;
            run_q      <= (state == ST_RUN);
            wea        <= wea_next;
            addra      <= addr_next;
            dina       <= data_next;
        end
    end

    always_comb begin
        state_next = state;
        sweep_next = sweep_addr;
        wea_next   = 1'b0;
        addr_next  = addra;
        data_next  = dina;
        alu_fire   = 1'b0;
        fifo_pop   = 1'b0;
        case (state)
            ST_INIT: begin
                wea_next   = 1'b1;
                addr_next  = sweep_addr;
                data_next  = '0;
                sweep_next = sweep_addr + AW'(1);
                if (sweep_addr == SWEEP_LAST) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (run_q && alu_valid) begin
                    alu_fire  = 1'b1;
                    wea_next  = 1'b1;
                    addr_next = alu_addr;
                    data_next = alu_data;
                end else if (run_q && fifo_count != '0) begin
                    fifo_pop = 1'b1;
                    if (head_valid) begin
                        wea_next  = 1'b1;
                        addr_next = head_addr;
                        data_next = head_data;
                    end
                end
            end
            default: state_next = RESET_STATE;
        endcase
    end

    assign alu_ready = run_q;
    assign ld_ready  = run_q && (fifo_count < CW'(DEPTH));
    assign fifo_push = ld_valid && ld_ready;

`ifdef REG_WB_INIT_EN
    assign init_done = run_q;
`else
    assign init_done = 1'b1;
`endif

    assign rd_pending = (wea && addra == rd_addr) || fifo_hit ||
                        (alu_fire && alu_addr == rd_addr);

    reg_wb_fifo #(
        .DEPTH(DEPTH),
        .AW   (AW),
        .DW   (DW)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (fifo_push),
        .push_addr  (ld_addr),
        .push_data  (ld_data),
        .pop        (fifo_pop),
        .squash     (alu_fire),
        .squash_addr(alu_addr),
        .query_addr (rd_addr),
        .head_valid (head_valid),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .count      (fifo_count),
        .query_hit  (fifo_hit)
    );

endmodule

// File: tb/tb_reg_wb_writer.sv
// Bench for reg_wb_writer: per-cycle vector table with a write-port scoreboard,
// plus a reset / init-sweep sequence when REG_WB_INIT_EN is defined.
module tb_reg_wb_writer;
    import reg_wb_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = REG_AW;
    localparam int DW    = REG_DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          alu_valid = 1'b0;
    logic          alu_ready;
    logic [AW-1:0] alu_addr = '0;
    logic [DW-1:0] alu_data = '0;
    logic          ld_valid = 1'b0;
    logic          ld_ready;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_pending;
    logic          init_done;
    logic          wea;
    logic [AW-1:0] addra;
    logic [DW-1:0] dina;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_wb_writer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .rd_addr   (rd_addr),
        .rd_pending(rd_pending),
        .init_done (init_done),
        .wea       (wea),
        .addra     (addra),
        .dina      (dina)
    );

    typedef struct {
        logic          alu_v;
        logic [AW-1:0] alu_a;
        logic [DW-1:0] alu_d;
        logic          ld_v;
        logic [AW-1:0] ld_a;
        logic [DW-1:0] ld_d;
        logic [AW-1:0] rd_a;
        logic          x_ldr;
        logic          x_pend;
        logic          x_we;
        logic [AW-1:0] x_wa;
        logic [DW-1:0] x_wd;
    } vec_t;

    vec_t      vecs[$];
    wb_entry_t exp_q[$];

    function automatic vec_t mk(input int av, input int aa, input logic [31:0] ad,
                                input int lv, input int la, input logic [31:0] ld,
                                input int ra, input int xldr, input int xpend,
                                input int xwe, input int xwa, input logic [31:0] xwd);
        vec_t v;
        v.alu_v  = (av != 0);
        v.alu_a  = AW'(aa);
        v.alu_d  = DW'(ad);
        v.ld_v   = (lv != 0);
        v.ld_a   = AW'(la);
        v.ld_d   = DW'(ld);
        v.rd_a   = AW'(ra);
        v.x_ldr  = (xldr != 0);
        v.x_pend = (xpend != 0);
        v.x_we   = (xwe != 0);
        v.x_wa   = AW'(xwa);
        v.x_wd   = DW'(xwd);
        return v;
    endfunction

    // Each driven cycle queues the write expected on the port one cycle later.
    wb_entry_t got;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            got = exp_q.pop_front();
            checks++;
            if (wea !== got.valid || (got.valid && (addra !== got.addr || dina !== got.data))) begin
                errors++;
                $display("FAIL write_port: got wea=%0b addra=%0d dina=%h, want wea=%0b addra=%0d dina=%h",
                         wea, addra, dina, got.valid, got.addr, got.data);
            end
        end
    end

    task automatic apply(input int idx, input vec_t v);
        wb_entry_t e;
        @(negedge clk);
        alu_valid = v.alu_v;
        alu_addr  = v.alu_a;
        alu_data  = v.alu_d;
        ld_valid  = v.ld_v;
        ld_addr   = v.ld_a;
        ld_data   = v.ld_d;
        rd_addr   = v.rd_a;
        #1;
        checks++;
        if (alu_ready !== 1'b1) begin
            errors++;
            $display("FAIL alu_ready vec %0d: got %0b want 1", idx, alu_ready);
        end
        checks++;
        if (ld_ready !== v.x_ldr) begin
            errors++;
            $display("FAIL ld_ready vec %0d: got %0b want %0b", idx, ld_ready, v.x_ldr);
        end
        checks++;
        if (rd_pending !== v.x_pend) begin
            errors++;
            $display("FAIL rd_pending vec %0d: got %0b want %0b", idx, rd_pending, v.x_pend);
        end
        e.valid = v.x_we;
        e.addr  = v.x_wa;
        e.data  = v.x_wd;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_values(input logic want_done);
        checks++;
        if (wea !== 1'b0 || addra !== '0 || dina !== '0 || alu_ready !== 1'b0 ||
            ld_ready !== 1'b0 || init_done !== want_done) begin
            errors++;
            $display("FAIL reset_values: got wea=%0b addra=%0d dina=%h alu_rdy=%0b ld_rdy=%0b done=%0b, want 0 0 0 0 0 %0b",
                     wea, addra, dina, alu_ready, ld_ready, init_done, want_done);
        end
    endtask

    task automatic check_sweep(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (wea !== 1'b1 || addra !== AW'(i) || dina !== '0 || alu_ready !== 1'b0 ||
                ld_ready !== 1'b0 || init_done !== 1'b0) begin
                errors++;
                $display("FAIL init_sweep step %0d: got wea=%0b addra=%0d dina=%h rdy=%0b/%0b done=%0b",
                         i, wea, addra, dina, alu_ready, ld_ready, init_done);
            end
        end
    endtask

    initial begin
        vecs.push_back(mk(1, 3, 'hDEADBEEF, 0, 0, 0,     3, 1, 1, 1, 3, 'hDEADBEEF));
        vecs.push_back(mk(0, 0, 0,          0, 0, 0,     3, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,          0, 0, 0,     3, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 'h100,      1, 8, 'h800, 8, 1, 0, 1, 1, 'h100));
        vecs.push_back(mk(1, 2, 'h200,      1, 10, 'hA00, 8, 1, 1, 1, 2, 'h200));
        vecs.push_back(mk(1, 4, 'h400,      1, 11, 'hB00, 0, 1, 0, 1, 4, 'h400));
        vecs.push_back(mk(1, 6, 'h600,      1, 12, 'hC00, 12, 1, 0, 1, 6, 'h600));
        vecs.push_back(mk(1, 13, 'hD00,     1, 14, 'hE00, 12, 0, 1, 1, 13, 'hD00));
        vecs.push_back(mk(0, 0, 0,          0, 0, 0,     12, 0, 1, 1, 8, 'h800));
        vecs.push_back(mk(0, 0, 0,          0, 0, 0,     12, 1, 1, 1, 10, 'hA00));
        vecs.push_back(mk(0, 0, 0,          0, 0, 0,     12, 1, 1, 1, 11, 'hB00));
        vecs.push_back(mk(0, 0, 0,          0, 0, 0,     12, 1, 1, 1, 12, 'hC00));
        vecs.push_back(mk(0, 0, 0,          0, 0, 0,     12, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,          0, 0, 0,     12, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,          1, 5, 'h11,  5, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 5, 'h22,       0, 0, 0,     5, 1, 1, 1, 5, 'h22));
        vecs.push_back(mk(0, 0, 0,          0, 0, 0,     5, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,          0, 0, 0,     5, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 7, 'hAA,       1, 7, 'hBB,  7, 1, 1, 1, 7, 'hAA));
        vecs.push_back(mk(0, 0, 0,          0, 0, 0,     7, 1, 1, 1, 7, 'hBB));
        vecs.push_back(mk(0, 0, 0,          0, 0, 0,     7, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,          0, 0, 0,     7, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,          1, 9, 'h99,  9, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,          0, 0, 0,     9, 1, 1, 1, 9, 'h99));
        vecs.push_back(mk(0, 0, 0,          0, 0, 0,     9, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,          0, 0, 0,     9, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 'h1,        1, 2, 'h21,  2, 1, 0, 1, 0, 'h1));
        vecs.push_back(mk(1, 0, 'h2,        1, 2, 'h22,  2, 1, 1, 1, 0, 'h2));
        vecs.push_back(mk(1, 0, 'h3,        1, 2, 'h23,  2, 1, 1, 1, 0, 'h3));
        vecs.push_back(mk(1, 0, 'h4,        1, 2, 'h24,  2, 1, 1, 1, 0, 'h4));
        vecs.push_back(mk(1, 2, 'h2F,       0, 0, 0,     2, 0, 1, 1, 2, 'h2F));
        vecs.push_back(mk(0, 0, 0,          0, 0, 0,     2, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,          0, 0, 0,     2, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,          0, 0, 0,     2, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,          0, 0, 0,     2, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,          0, 0, 0,     2, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,          1, 15, 'hF,  15, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,          0, 0, 0,     15, 1, 1, 1, 15, 'hF));
        vecs.push_back(mk(0, 0, 0,          0, 0, 0,     15, 1, 1, 0, 0, 0));

        #12;
`ifdef REG_WB_INIT_EN
        check_reset_values(1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        check_sweep(6);
        rst_n = 1'b0;
        #1;
        check_reset_values(1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        check_sweep(16);
        @(posedge clk);
        #1;
        checks++;
        if (init_done !== 1'b1 || wea !== 1'b0 || addra !== INIT_LAST) begin
            errors++;
            $display("FAIL init_done_rise: got done=%0b wea=%0b addra=%0d, want 1 0 %0d",
                     init_done, wea, addra, INIT_LAST);
        end
`else
        check_reset_values(1'b1);
        @(negedge clk);
        rst_n = 1'b1;
`endif
        begin
            int n = 0;
            while (alu_ready !== 1'b1 && n < 200) begin
                @(posedge clk);
                #1;
                n++;
            end
            checks++;
            if (alu_ready !== 1'b1) begin
                errors++;
                $display("FAIL ready_timeout: got alu_ready=%0b after %0d cycles, want 1", alu_ready, n);
            end
        end

        foreach (vecs[i]) apply(i, vecs[i]);

        @(negedge clk);
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
